// File: rtl/occupancy_bcd_counter.sv
// Car-park occupancy counter: tracks enter/exit ticks up to CAPACITY and keeps
// a binary count alongside a three-digit BCD copy for the display.
module occupancy_bcd_counter #(
  parameter int CAPACITY = 99,
  parameter int CW       = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc,
  input  logic          dec,
  input  logic          clr,
  output logic [CW-1:0] cnt,
  output logic [3:0]    bcd2,
  output logic [3:0]    bcd1,
  output logic [3:0]    bcd0,
  output logic          full,
  output logic          empty,
  output logic          ovf_tick,
  output logic          unf_tick
);

  localparam logic [CW-1:0] CAP_C  = CW'(CAPACITY);
  localparam logic [CW-1:0] ONE_C  = CW'(1);
  localparam logic [CW-1:0] ZERO_C = CW'(0);

  // Ripple a +1 through the three digits, units first.
  function automatic logic [11:0] bcd_inc(input logic [11:0] v);
    logic [11:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (carry) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
          carry       = 1'b1;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end else begin
        r[4*i +: 4] = v[4*i +: 4];
      end
    end
    return r;
  endfunction

  // Ripple a -1 through the three digits, units first.
  function automatic logic [11:0] bcd_dec(input logic [11:0] v);
    logic [11:0] r;
    logic        borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
          borrow      = 1'b1;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end else begin
        r[4*i +: 4] = v[4*i +: 4];
      end
    end
    return r;
  endfunction

  logic [CW-1:0] cnt_q, cnt_d;
  logic [11:0]   bcd_q, bcd_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;

  // Next-state: clear beats everything; simultaneous inc/dec cancels.
  always_comb begin
    cnt_d = cnt_q;
    bcd_d = bcd_q;
    ovf_d = 1'b0;
    unf_d = 1'b0;
    if (clr) begin
      cnt_d = ZERO_C;
      bcd_d = 12'd0;
    end else if (inc && !dec) begin
      if (cnt_q == CAP_C) begin
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + ONE_C;
        bcd_d = bcd_inc(bcd_q);
      end
    end else if (dec && !inc) begin
      if (cnt_q == ZERO_C) begin
        unf_d = 1'b1;
      end else begin
        cnt_d = cnt_q - ONE_C;
        bcd_d = bcd_dec(bcd_q);
      end
    end else begin
      cnt_d = cnt_q;
      bcd_d = bcd_q;
    end
    // Flags decode the next count so they move together with cnt.
    full_d  = (cnt_d == CAP_C);
    empty_d = (cnt_d == ZERO_C);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= ZERO_C;
      bcd_q   <= 12'd0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign cnt      = cnt_q;
  assign bcd2     = bcd_q[11:8];
  assign bcd1     = bcd_q[7:4];
  assign bcd0     = bcd_q[3:0];
  assign full     = full_q;
  assign empty    = empty_q;
  assign ovf_tick = ovf_q;
  assign unf_tick = unf_q;

endmodule
